// File: rtl/servo_pwm_pkg.sv
// Shared constants for the turret servo PWM APB slave: register offsets,
// reset values, STATUS bit layout and the target clamp helper.
package servo_pwm_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_CTRL   = 8'h00;
   localparam logic [ADDR_W-1:0] REG_PERIOD = 8'h04;
   localparam logic [ADDR_W-1:0] REG_TARGET = 8'h08;
   localparam logic [ADDR_W-1:0] REG_STEP   = 8'h0C;
   localparam logic [ADDR_W-1:0] REG_STATUS = 8'h10;

   localparam int unsigned RST_PERIOD = 20000;
   localparam int unsigned RST_TARGET = 1500;
   localparam int unsigned RST_STEP   = 10;
   localparam int unsigned RST_PW     = 1500;

   localparam int unsigned STAT_PW_W          = 16;
   localparam int unsigned STAT_AT_TARGET_BIT = 16;
   localparam int unsigned STAT_IRQ_BIT       = 17;

   // Clamp on the full bus word so large writes cannot wrap into range.
   function automatic logic [DATA_W-1:0] clamp_u32(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] lo,
                                                   input logic [DATA_W-1:0] hi);
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/servo_slew.sv
// Step limiter: on an update strobe, moves cur_pw toward target by at most
// step (step==0 jumps straight to target); holds cur_pw otherwise.
module servo_slew
   import servo_pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic [CNT_W-1:0] cur_pw_i,
   input  logic [CNT_W-1:0] target_i,
   input  logic [CNT_W-1:0] step_i,
   input  logic             update_i,
   output logic [CNT_W-1:0] next_pw_o
);

   logic             up_c;
   logic [CNT_W-1:0] diff_c;

   // Compare first so the distance never wraps.
   always_comb begin
      up_c   = 1'b0;
      diff_c = '0;
      if (target_i >= cur_pw_i) begin
         up_c   = 1'b1;
         diff_c = target_i - cur_pw_i;
      end else begin
         diff_c = cur_pw_i - target_i;
      end
   end

   always_comb begin
      next_pw_o = cur_pw_i;
      if (update_i) begin
         if ((step_i == '0) || (diff_c <= step_i)) begin
            next_pw_o = target_i;
         end else if (up_c) begin
            next_pw_o = cur_pw_i + step_i;
         end else begin
            next_pw_o = cur_pw_i - step_i;
         end
      end
   end

endmodule

// File: rtl/servo_pwm_apb.sv
// APB3 slave driving the turret servo PWM with per-period slew limiting.
// Optional arrival interrupt enabled by defining SERVO_PWM_IRQ_EN.
module servo_pwm_apb
   import servo_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = 100,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MIN_PW   = 1000,
   parameter int unsigned MAX_PW   = 2000
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              PWM,
   output logic              IRQ
);

   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic             en_q, en_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] cur_pw_q, cur_pw_d;
   logic [CNT_W-1:0] per_active_q, per_active_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             pwm_q, pwm_d;
   logic             irq_q, irq_d;

   logic              wr_c;
   logic [ADDR_W-1:0] reg_off_c;
   logic              tick_c;
   logic              per_zero_c;
   logic              wrap_c;
   logic              at_target_c;
   logic [DATA_W-1:0] status_c;
   logic              unused_paddr;

   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;
   assign PWM     = pwm_q;
   assign IRQ     = irq_q;

   // Only PADDR[4:2] selects a register; the rest of the address is ignored.
   assign reg_off_c    = {3'b000, PADDR[4:2], 2'b00};
   assign wr_c         = PSEL & PENABLE & PWRITE;
   assign unused_paddr = ^{PADDR[7:5], PADDR[1:0]};

   always_comb begin : reg_write
      en_d     = en_q;
      period_d = period_q;
      target_d = target_q;
      step_d   = step_q;
      if (wr_c) begin
         case (reg_off_c)
            REG_CTRL:   en_d     = PWDATA[0];
            REG_PERIOD: period_d = PWDATA[CNT_W-1:0];
            REG_TARGET: target_d = CNT_W'(clamp_u32(PWDATA, DATA_W'(MIN_PW), DATA_W'(MAX_PW)));
            REG_STEP:   step_d   = PWDATA[CNT_W-1:0];
            default:    ;
         endcase
      end
   end

   assign tick_c     = en_q & (pre_q == PRE_W'(PRESCALE - 1));
   assign per_zero_c = (per_active_q == '0);
   assign wrap_c     = tick_c & ~per_zero_c & (pcnt_q == (per_active_q - CNT_W'(1)));

   // While disabled the shadow period tracks PERIOD, so it holds the right
   // value the moment EN rises; a zero shadow retries the reload every tick.
   always_comb begin : counters
      pre_d        = pre_q;
      pcnt_d       = pcnt_q;
      per_active_d = per_active_q;
      if (!en_q) begin
         pre_d        = '0;
         pcnt_d       = '0;
         per_active_d = period_q;
      end else begin
         pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
         if (tick_c) begin
            if (per_zero_c) begin
               per_active_d = period_q;
            end else if (wrap_c) begin
               pcnt_d       = '0;
               per_active_d = period_q;
            end else begin
               pcnt_d = pcnt_q + CNT_W'(1);
            end
         end
      end
   end

   servo_slew #(
      .CNT_W(CNT_W)
   ) u_slew (
      .cur_pw_i (cur_pw_q),
      .target_i (target_q),
      .step_i   (step_q),
      .update_i (wrap_c),
      .next_pw_o(cur_pw_d)
   );

   // en_d drops the pulse at the committing edge; en_q keeps the first
   // period after enable from gaining an extra high cycle.
   assign pwm_d = en_q & en_d & ~per_zero_c & (pcnt_q < cur_pw_q);

   assign at_target_c = (cur_pw_q == target_q);

`ifdef SERVO_PWM_IRQ_EN
   assign irq_d = (wrap_c & (cur_pw_d == target_q) & (cur_pw_q != target_q)) |
                  (irq_q & ~(wr_c & (reg_off_c == REG_STATUS)));
`else
   assign irq_d = 1'b0;
`endif

   always_comb begin : status_word
      status_c                     = '0;
      status_c[STAT_PW_W-1:0]      = STAT_PW_W'(cur_pw_q);
      status_c[STAT_AT_TARGET_BIT] = at_target_c;
      status_c[STAT_IRQ_BIT]       = irq_q;
   end

   always_comb begin : read_mux
      PRDATA = '0;
      if (PSEL) begin
         case (reg_off_c)
            REG_CTRL:   PRDATA = {{(DATA_W-1){1'b0}}, en_q};
            REG_PERIOD: PRDATA = DATA_W'(period_q);
            REG_TARGET: PRDATA = DATA_W'(target_q);
            REG_STEP:   PRDATA = DATA_W'(step_q);
            REG_STATUS: PRDATA = status_c;
            default:    PRDATA = '0;
         endcase
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         en_q         <= 1'b0;
         period_q     <= CNT_W'(RST_PERIOD);
         target_q     <= CNT_W'(RST_TARGET);
         step_q       <= CNT_W'(RST_STEP);
         cur_pw_q     <= CNT_W'(RST_PW);
         per_active_q <= CNT_W'(RST_PERIOD);
         pcnt_q       <= '0;
         pre_q        <= '0;
         pwm_q        <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         en_q         <= en_d;
         period_q     <= period_d;
         target_q     <= target_d;
         step_q       <= step_d;
         cur_pw_q     <= cur_pw_d;
         per_active_q <= per_active_d;
         pcnt_q       <= pcnt_d;
         pre_q        <= pre_d;
         pwm_q        <= pwm_d;
         irq_q        <= irq_d;
      end
   end

endmodule

// File: tb/tb_servo_pwm_apb.sv
// Directed bench for servo_pwm_apb: register table plus PWM timing, slew,
// period-change, boundary, disable and async-reset sequences.
module tb_servo_pwm_apb;

   localparam int unsigned PRESCALE = 2;
`ifdef SERVO_PWM_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        PCLK;
   logic        PRESET;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        PWM;
   logic        IRQ;

   int n_checks = 0;
   int n_fail   = 0;

   servo_pwm_apb #(
      .PRESCALE(PRESCALE),
      .CNT_W   (16),
      .MIN_PW  (1000),
      .MAX_PW  (2000)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR),
      .PWM    (PWM),
      .IRQ    (IRQ)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [31:0] stat(input int pw, input logic at, input logic irq);
      return {14'b0, irq, at, 16'(pw)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1 data = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Counts negedges until PWM equals lvl; returns max_cyc if it never does.
   task automatic wait_pwm(input logic lvl, input int max_cyc, output int n);
      n = 0;
      while (PWM !== lvl && n < max_cyc) begin
         @(negedge PCLK);
         n++;
      end
   endtask

   task automatic apply_vecs(input int lo, input int hi);
      logic [31:0] rd;
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].wdata);
         apb_read(vecs[i].addr, rd);
         check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), rd, vecs[i].exp);
      end
   endtask

   initial begin
      logic [31:0] rd;
      int n;

      vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'd20000};
      vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'd1500};
      vecs[3]  = '{1'b0, 8'h0C, 32'h0,         32'd10};
      vecs[4]  = '{1'b0, 8'h10, 32'h0,         32'h0001_05DC};
      vecs[5]  = '{1'b0, 8'h14, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 8'h08, 32'd5000,      32'd2000};
      vecs[7]  = '{1'b1, 8'h08, 32'd10,        32'd1000};
      vecs[8]  = '{1'b1, 8'h08, 32'd1777,      32'd1777};
      vecs[9]  = '{1'b1, 8'h08, 32'd1500,      32'd1500};
      vecs[10] = '{1'b1, 8'h0C, 32'h0001_2345, 32'h0000_2345};
      vecs[11] = '{1'b1, 8'h0C, 32'd10,        32'd10};
      vecs[12] = '{1'b1, 8'h18, 32'h0000_FFFF, 32'h0};
      vecs[13] = '{1'b1, 8'h10, 32'h0,         32'h0001_05DC};
      vecs[14] = '{1'b1, 8'h04, 32'd2000,      32'd2000};
      vecs[15] = '{1'b1, 8'h00, 32'hFFFF_FFFE, 32'h0};

      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 8'h04; PWDATA = 32'h0;
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);

      // Reset state and idle bus
      check("reset_pwm", 32'(PWM), 32'd0);
      check("reset_irq", 32'(IRQ), 32'd0);
      check("idle_prdata", PRDATA, 32'd0);
      check("pready", 32'(PREADY), 32'd1);
      check("pslverr", 32'(PSLVERR), 32'd0);
      apply_vecs(0, 15);
      wait_pwm(1'b1, 200, n);
      check("pwm_low_while_disabled", 32'(n), 32'd200);

      // Steady waveform: PERIOD=2000, cur_pw=1500, 2 PCLK per tick
      apb_write(8'h00, 32'd1);
      wait_pwm(1'b1, 50, n);
      check("first_rise_after_en", 32'(n < 50), 32'd1);
      wait_pwm(1'b0, 10000, n);
      check("high_1500", 32'(n), 32'd3000);
      wait_pwm(1'b1, 10000, n);
      check("low_1500", 32'(n), 32'd1000);

      // Slew 1500 -> 1530 in steps of 10, one step per wrap
      apb_write(8'h08, 32'd1530);
      wait_pwm(1'b0, 10000, n);
      wait_pwm(1'b1, 10000, n);
      wait_pwm(1'b0, 10000, n);
      check("high_1510", 32'(n), 32'd3020);
      apb_read(8'h10, rd);
      check("status_1510", rd, stat(1510, 1'b0, 1'b0));
      check("irq_not_yet", 32'(IRQ), 32'd0);
      wait_pwm(1'b1, 10000, n);
      wait_pwm(1'b0, 10000, n);
      check("high_1520", 32'(n), 32'd3040);
      apb_read(8'h10, rd);
      check("status_1520", rd, stat(1520, 1'b0, 1'b0));
      wait_pwm(1'b1, 10000, n);
      wait_pwm(1'b0, 10000, n);
      check("high_1530", 32'(n), 32'd3060);
      apb_read(8'h10, rd);
      check("status_1530", rd, stat(1530, 1'b1, IRQ_ON));
      check("irq_arrival", 32'(IRQ), 32'(IRQ_ON));
      apb_write(8'h10, 32'h0);
      check("irq_cleared", 32'(IRQ), 32'd0);
      apb_read(8'h10, rd);
      check("status_after_clear", rd, stat(1530, 1'b1, 1'b0));

      // PERIOD write mid-period applies at the next boundary
      wait_pwm(1'b1, 10000, n);
      apb_write(8'h04, 32'd1600);
      wait_pwm(1'b0, 10000, n);
      wait_pwm(1'b1, 10000, n);
      check("low_old_period", 32'(n), 32'd940);
      wait_pwm(1'b0, 10000, n);
      check("high_new_period", 32'(n), 32'd3060);
      wait_pwm(1'b1, 10000, n);
      check("low_new_period", 32'(n), 32'd140);

      // cur_pw >= period: constant high from the next boundary
      apb_write(8'h04, 32'd1000);
      wait_pwm(1'b0, 10000, n);
      wait_pwm(1'b1, 10000, n);
      check("low_before_short", 32'(n), 32'd140);
      wait_pwm(1'b0, 5000, n);
      check("const_high", 32'(n), 32'd5000);

      // Zero period: PWM held low, cur_pw frozen
      apb_write(8'h04, 32'd0);
      wait_pwm(1'b0, 2100, n);
      check("zero_period_low", 32'(n < 2100), 32'd1);
      apb_write(8'h08, 32'd1000);
      wait_pwm(1'b1, 3000, n);
      check("zero_period_hold", 32'(n), 32'd3000);
      apb_read(8'h10, rd);
      check("zero_period_frozen", rd, stat(1530, 1'b0, 1'b0));

      // Disable mid-pulse truncates and freezes cur_pw
      apb_write(8'h08, 32'd1530);
      apb_write(8'h04, 32'd2000);
      wait_pwm(1'b1, 50, n);
      check("restart_rise", 32'(n < 50), 32'd1);
      repeat (20) @(negedge PCLK);
      check("pulse_before_disable", 32'(PWM), 32'd1);
      apb_write(8'h00, 32'd0);
      check("pwm_off_next_edge", 32'(PWM), 32'd0);
      apb_read(8'h10, rd);
      check("disable_status", rd, stat(1530, 1'b1, 1'b0));
      wait_pwm(1'b1, 500, n);
      check("disabled_stays_low", 32'(n), 32'd500);

      // Async reset during a high pulse
      apb_write(8'h00, 32'd1);
      wait_pwm(1'b1, 50, n);
      repeat (10) @(negedge PCLK);
      check("pulse_before_reset", 32'(PWM), 32'd1);
      #2 PRESET = 1'b1;
      #1 check("async_reset_pwm", 32'(PWM), 32'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      apply_vecs(0, 5);
      wait_pwm(1'b1, 100, n);
      check("post_reset_low", 32'(n), 32'd100);
      check("post_reset_irq", 32'(IRQ), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
